instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/fetch_pkg.sv | 18 +
 rtl/if_hold_buffer.sv | 30 +++
 rtl/instr_fetch.sv | 98 +++++++++
 tb/tb_instr_fetch.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Imported by instr_fetch and if_hold_buffer.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

    typedef enum logic [1:0] {
        EMPTY,
        RUN,
        HOLD
    } state_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_hold_buffer.sv
// Capture register for a stalled imem response, with a bypass mux
// that forwards the live memory data whenever nothing is held.
module if_hold_buffer
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               capture,
    input  logic               clear,
    input  logic [INSTR_W-1:0] din,
    input  logic [INSTR_W-1:0] live,
    output logic [INSTR_W-1:0] dout,
    output logic               held
);

    logic [INSTR_W-1:0] data;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            data <= NOP_INSTR;
            held <= 1'b0;
        end else if (capture) begin
            data <= din;
            held <= 1'b1;
        end
    end

    assign dout = held ? data : live;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage over a 1-cycle synchronous instruction memory.
// Stalls park the in-flight response in a hold buffer; redirects squash.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               imem_en,
    output logic [31:0]        imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_pc_plus4,
    output logic [INSTR_W-1:0] if_instr
);

    state_t      state, state_n;
    logic [31:0] fetch_pc, fetch_n;
    logic [31:0] resp_pc, resp_n;
    logic        capture, clear, held;
    logic [INSTR_W-1:0] buf_out;

    if_hold_buffer u_hold (
        .clk     (clk),
        .rst     (rst),
        .capture (capture),
        .clear   (clear),
        .din     (imem_rdata),
        .live    (imem_rdata),
        .dout    (buf_out),
        .held    (held)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_n;
            resp_pc  <= resp_n;
        end
    end

    always_comb begin
        state_n = state;
        fetch_n = fetch_pc;
        resp_n  = resp_pc;
        capture = 1'b0;
        clear   = 1'b0;
        if (redirect) begin
            fetch_n = align_pc(redirect_pc);
            state_n = EMPTY;
            clear   = 1'b1;
        end else begin
            unique case (state)
                EMPTY: begin
                    resp_n  = fetch_pc;
                    fetch_n = fetch_pc + 32'd4;
                    state_n = RUN;
                end
                RUN: begin
                    if (stall) begin
                        capture = 1'b1;
                        state_n = HOLD;
                    end else begin
                        resp_n  = fetch_pc;
                        fetch_n = fetch_pc + 32'd4;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        resp_n  = fetch_pc;
                        fetch_n = fetch_pc + 32'd4;
                        clear   = 1'b1;
                        state_n = RUN;
                    end
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    // A same-cycle redirect squashes the presented instruction.
    assign if_valid    = (state != EMPTY) && !redirect;
    assign if_instr    = if_valid ? buf_out : NOP_INSTR;
    assign if_pc       = resp_pc;
    assign if_pc_plus4 = resp_pc + 32'd4;
    assign imem_en     = !rst;
    assign imem_addr   = fetch_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch against an instruction-stream model.
// The imem model returns addr ^ A5A5_0000 with one cycle of latency.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] KEY    = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instr;

    int n_chk;
    int n_fail;

    // Model: the instruction on display and the next address to fetch.
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_next;

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4),
        .if_instr    (if_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= imem_addr ^ KEY;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive, check mid-cycle, advance the model at the edge.
    task automatic step(input logic r, input logic s, input logic d,
                        input logic [31:0] t);
        logic sq;
        rst = r;
        stall = s;
        redirect = d;
        redirect_pc = t;
        #4;
        sq = m_valid && !d;
        chk("valid", {31'b0, if_valid}, {31'b0, sq});
        chk("pc", if_pc, m_pc);
        chk("pc4", if_pc_plus4, m_pc + 32'd4);
        chk("instr", if_instr, sq ? (m_pc ^ KEY) : 32'h0);
        chk("en", {31'b0, imem_en}, {31'b0, !r});
        chk("addr", imem_addr, m_next);
        @(posedge clk);
        if (r) begin
            m_valid = 1'b0;
            m_pc    = RST_PC;
            m_next  = RST_PC;
        end else if (d) begin
            m_valid = 1'b0;
            m_next  = t & 32'hFFFF_FFFC;
        end else if (!m_valid) begin
            m_valid = 1'b1;
            m_pc    = m_next;
            m_next  = m_next + 32'd4;
        end else if (!s) begin
            m_pc    = m_next;
            m_next  = m_next + 32'd4;
        end
        #1;
    endtask

    // Drive idle inputs and sample, for directed point checks.
    task automatic peek;
        rst = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] tgt;
        n_chk = 0;
        n_fail = 0;
        m_valid = 1'b0;
        m_pc = 32'hx;
        m_next = 32'hx;
        imem_rdata = 32'h0;
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        @(posedge clk);
        #1;
        m_pc = RST_PC;
        m_next = RST_PC;
        repeat (2) step(1, 0, 0, 0);

        // Reset release, straight-line fetch up to pc=8.
        step(0, 0, 0, 0);
        peek();
        chk("r_first_pc", if_pc, 32'h0);
        chk("r_first_in", if_instr, 32'hA5A5_0000);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        peek();
        chk("r_pc8", if_pc, 32'h8);

        // Three-cycle stall on pc=8.
        repeat (3) step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        peek();
        chk("stall_next", if_instr, 32'hA5A5_000C);

        // Redirect to 0x100.
        step(0, 0, 1, 32'h100);
        step(0, 0, 0, 0);
        peek();
        chk("redir_pc", if_pc, 32'h100);
        chk("redir_in", if_instr, 32'hA5A5_0100);

        // Redirect with stall while holding.
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 32'h240);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);

        // Unaligned target near the top of memory, then wrap.
        step(0, 0, 1, 32'hFFFF_FFFE);
        step(0, 0, 0, 0);
        peek();
        chk("wrap_top", if_pc, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        peek();
        chk("wrap_zero", if_pc, 32'h0);

        // Reset in the middle of a hold.
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 1, 32'h800);
        peek();
        chk("rst_hold_v", {31'b0, if_valid}, 32'h0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Random interleavings.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 0)
                tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else
                tgt = $urandom;
            step($urandom_range(0, 59) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 9) == 0,
                 tgt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
